// File: rtl/func_gen_pkg.sv
// Shared types and constants for the function-generator NCO address path.
package func_gen_pkg;

    // Per-channel sequencing state
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } ch_state_e;

    // Which shadow register a config write targets
    typedef enum logic [1:0] {
        CFG_DIV  = 2'd0,
        CFG_INC  = 2'd1,
        CFG_OFF  = 2'd2,
        CFG_MODE = 2'd3
    } cfg_sel_e;

    // MODE register layout
    localparam int MODE_BURST_BIT = 0;
    localparam int BURST_CNT_LSB  = 16;
    localparam int BURST_CNT_MSB  = 31;
    localparam int BURST_W        = BURST_CNT_MSB - BURST_CNT_LSB + 1;

endpackage

// File: rtl/func_gen_nco_ch.sv
// One NCO channel: shadow/active config, prescaler, phase accumulator and
// IDLE/RUN/DONE sequencing. Config retunes land only on a waveform wrap while
// running, so the output never glitches mid-period.
module func_gen_nco_ch
    import func_gen_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int ACC_W  = 32,
    parameter int DIV_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ch_en,
    input  logic              start,
    input  logic              sync_in,
    input  logic              cfg_we,
    input  logic [1:0]        cfg_sel,
    input  logic [31:0]       cfg_data,
    output logic [ADDR_W-1:0] addr,
    output logic              wrap,
    output logic              done
);

    // Default increment gives exactly one LUT step per tick
    localparam logic [ACC_W-1:0] INC_RESET = ACC_W'(1) << (ACC_W - ADDR_W);

    // Shadow (software-visible) config
    logic [DIV_W-1:0]   sh_div_reg,   sh_div_next;
    logic [ACC_W-1:0]   sh_inc_reg,   sh_inc_next;
    logic [ADDR_W-1:0]  sh_off_reg,   sh_off_next;
    logic               sh_burst_reg, sh_burst_next;
    logic [BURST_W-1:0] sh_bcnt_reg,  sh_bcnt_next;

    // Active (in-use) config
    logic [DIV_W-1:0]   act_div_reg,   act_div_next;
    logic [ACC_W-1:0]   act_inc_reg,   act_inc_next;
    logic [ADDR_W-1:0]  act_off_reg,   act_off_next;
    logic               act_burst_reg, act_burst_next;
    logic [BURST_W-1:0] act_bcnt_reg,  act_bcnt_next;

    // Running state
    ch_state_e          state_reg;
    logic [DIV_W-1:0]   cnt_reg;
    logic [ACC_W-1:0]   acc_reg;
    logic [BURST_W-1:0] burst_left_reg;
    logic [ADDR_W-1:0]  addr_reg;
    logic               wrap_reg;
    logic               done_reg;

    // Datapath helpers
    logic               tick;
    logic [ACC_W:0]     sum_full;
    logic [ADDR_W-1:0]  addr_from_acc;
    logic               wrap_evt;

    // Shadow register write decode
    always_comb begin
        sh_div_next   = sh_div_reg;
        sh_inc_next   = sh_inc_reg;
        sh_off_next   = sh_off_reg;
        sh_burst_next = sh_burst_reg;
        sh_bcnt_next  = sh_bcnt_reg;
        if (cfg_we) begin
            case (cfg_sel_e'(cfg_sel))
                CFG_DIV:  sh_div_next = DIV_W'(cfg_data);
                CFG_INC:  sh_inc_next = ACC_W'(cfg_data);
                CFG_OFF:  sh_off_next = ADDR_W'(cfg_data);
                CFG_MODE: begin
                    sh_burst_next = cfg_data[MODE_BURST_BIT];
                    sh_bcnt_next  = cfg_data[BURST_CNT_MSB:BURST_CNT_LSB];
                end
                default: ;
            endcase
        end
    end

    // Prescaler tick, accumulator sum with carry, and the wrap event that drives commits
    always_comb begin
        tick          = (cnt_reg == act_div_reg);
        sum_full      = {1'b0, acc_reg} + {1'b0, act_inc_reg};
        addr_from_acc = sum_full[ACC_W-1 -: ADDR_W] + act_off_reg;
        wrap_evt      = (state_reg == ST_RUN) && ch_en && !sync_in && tick && sum_full[ACC_W];
    end

    // Active config: follow the shadow (including a same-cycle write) while not
    // running; while running, take the pre-write shadow only on a wrap
    always_comb begin
        act_div_next   = act_div_reg;
        act_inc_next   = act_inc_reg;
        act_off_next   = act_off_reg;
        act_burst_next = act_burst_reg;
        act_bcnt_next  = act_bcnt_reg;
        if (state_reg != ST_RUN) begin
            act_div_next   = sh_div_next;
            act_inc_next   = sh_inc_next;
            act_off_next   = sh_off_next;
            act_burst_next = sh_burst_next;
            act_bcnt_next  = sh_bcnt_next;
        end else if (wrap_evt) begin
            act_div_next   = sh_div_reg;
            act_inc_next   = sh_inc_reg;
            act_off_next   = sh_off_reg;
            act_burst_next = sh_burst_reg;
            act_bcnt_next  = sh_bcnt_reg;
        end
    end

    // Config register storage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_div_reg    <= '0;
            sh_inc_reg    <= INC_RESET;
            sh_off_reg    <= '0;
            sh_burst_reg  <= 1'b0;
            sh_bcnt_reg   <= '0;
            act_div_reg   <= '0;
            act_inc_reg   <= INC_RESET;
            act_off_reg   <= '0;
            act_burst_reg <= 1'b0;
            act_bcnt_reg  <= '0;
        end else begin
            sh_div_reg    <= sh_div_next;
            sh_inc_reg    <= sh_inc_next;
            sh_off_reg    <= sh_off_next;
            sh_burst_reg  <= sh_burst_next;
            sh_bcnt_reg   <= sh_bcnt_next;
            act_div_reg   <= act_div_next;
            act_inc_reg   <= act_inc_next;
            act_off_reg   <= act_off_next;
            act_burst_reg <= act_burst_next;
            act_bcnt_reg  <= act_bcnt_next;
        end
    end

    // Channel FSM with prescaler, accumulator and registered outputs.
    // Priority: ch_en low, then sync_in, then the prescaler tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= ST_IDLE;
            cnt_reg        <= '0;
            acc_reg        <= '0;
            burst_left_reg <= '0;
            addr_reg       <= '0;
            wrap_reg       <= 1'b0;
            done_reg       <= 1'b0;
        end else begin
            wrap_reg <= 1'b0;
            if (!ch_en) begin
                state_reg <= ST_IDLE;
                cnt_reg   <= '0;
                acc_reg   <= '0;
                addr_reg  <= act_off_reg;
                done_reg  <= 1'b0;
            end else begin
                case (state_reg)
                    ST_IDLE: begin
                        cnt_reg  <= '0;
                        acc_reg  <= '0;
                        addr_reg <= act_off_reg;
                        if (!act_burst_reg || start) begin
                            state_reg      <= ST_RUN;
                            burst_left_reg <= act_bcnt_reg;
                        end
                    end
                    ST_RUN: begin
                        if (sync_in) begin
                            cnt_reg  <= '0;
                            acc_reg  <= '0;
                            addr_reg <= act_off_reg;
                        end else if (tick) begin
                            cnt_reg  <= '0;
                            acc_reg  <= sum_full[ACC_W-1:0];
                            addr_reg <= addr_from_acc;
                            wrap_reg <= sum_full[ACC_W];
                            // A zero burst count never reaches DONE (unbounded burst)
                            if (sum_full[ACC_W] && act_burst_reg && (burst_left_reg != '0)) begin
                                burst_left_reg <= burst_left_reg - BURST_W'(1);
                                if (burst_left_reg == BURST_W'(1)) begin
                                    state_reg <= ST_DONE;
                                    done_reg  <= 1'b1;
                                end
                            end
                        end else begin
                            cnt_reg <= cnt_reg + DIV_W'(1);
                        end
                    end
                    ST_DONE: begin
                        cnt_reg  <= '0;
                        acc_reg  <= '0;
                        addr_reg <= act_off_reg;
                        if (start) begin
                            state_reg      <= ST_RUN;
                            burst_left_reg <= act_bcnt_reg;
                            done_reg       <= 1'b0;
                        end
                    end
                    default: begin
                        state_reg <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign addr = addr_reg;
    assign wrap = wrap_reg;
    assign done = done_reg;

endmodule

// File: rtl/func_gen_nco.sv
// Multi-channel LUT address generator: decodes config writes to the target
// channel and fans sync_in out to every channel.
module func_gen_nco
    import func_gen_pkg::*;
#(
    parameter int NUM_CH = 2,
    parameter int ADDR_W = 10,
    parameter int ACC_W  = 32,
    parameter int DIV_W  = 32,
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_CH-1:0]              ch_en,
    input  logic [NUM_CH-1:0]              start,
    input  logic                           sync_in,
    input  logic                           cfg_we,
    input  logic [CH_W-1:0]                cfg_ch,
    input  logic [1:0]                     cfg_sel,
    input  logic [31:0]                    cfg_data,
    output logic [NUM_CH-1:0][ADDR_W-1:0]  addr,
    output logic [NUM_CH-1:0]              wrap,
    output logic [NUM_CH-1:0]              done
);

    logic cfg_in_range;

    // Writes to a channel index that does not exist are dropped
    always_comb begin
        cfg_in_range = (int'(cfg_ch) < NUM_CH);
    end

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        logic ch_we;

        assign ch_we = cfg_we && cfg_in_range && (cfg_ch == CH_W'(gi));

        func_gen_nco_ch #(
            .ADDR_W (ADDR_W),
            .ACC_W  (ACC_W),
            .DIV_W  (DIV_W)
        ) u_ch (
            .clk      (clk),
            .rst_n    (rst_n),
            .ch_en    (ch_en[gi]),
            .start    (start[gi]),
            .sync_in  (sync_in),
            .cfg_we   (ch_we),
            .cfg_sel  (cfg_sel),
            .cfg_data (cfg_data),
            .addr     (addr[gi]),
            .wrap     (wrap[gi]),
            .done     (done[gi])
        );
    end

endmodule

// File: tb/tb_func_gen_nco.sv
// Self-checking bench for func_gen_nco: directed vector table, randomized
// continuous runs against a closed-form phase model, and hand-written
// sequences for burst, retune, sync and asynchronous reset.
module tb_func_gen_nco;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [1:0]       ch_en;
    logic [1:0]       start;
    logic             sync_in;
    logic             cfg_we;
    logic [0:0]       cfg_ch;
    logic [1:0]       cfg_sel;
    logic [31:0]      cfg_data;
    logic [1:0][9:0]  addr;
    logic [1:0]       wrap;
    logic [1:0]       done;

    int errors = 0;
    int checks = 0;

    func_gen_nco #(.NUM_CH(2), .ADDR_W(10), .ACC_W(32), .DIV_W(32)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ch_en    (ch_en),
        .start    (start),
        .sync_in  (sync_in),
        .cfg_we   (cfg_we),
        .cfg_ch   (cfg_ch),
        .cfg_sel  (cfg_sel),
        .cfg_data (cfg_data),
        .addr     (addr),
        .wrap     (wrap),
        .done     (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] div;
        logic [31:0] inc;
        logic [9:0]  off;
        int          cyc;
        logic [9:0]  exp_addr;
        logic        exp_wrap;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Advance n rising edges and land 1 ns after the last one
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic cfg_wr(input int ch, input int sel, input logic [31:0] d);
        cfg_we   = 1'b1;
        cfg_ch   = 1'(ch);
        cfg_sel  = 2'(sel);
        cfg_data = d;
        step(1);
        cfg_we   = 1'b0;
    endtask

    task automatic setup(input int ch, input logic [31:0] div, input logic [31:0] inc,
                         input logic [31:0] off, input logic [31:0] mode);
        cfg_wr(ch, 0, div);
        cfg_wr(ch, 1, inc);
        cfg_wr(ch, 2, off);
        cfg_wr(ch, 3, mode);
    endtask

    // Ideal continuous NCO: n cycles after entering RUN, k = n/(div+1) ticks
    // have occurred and the phase is k*inc; a wrap happens on a tick whose
    // phase crosses a multiple of 2**32.
    task automatic model(input int n, input logic [31:0] div, input logic [31:0] inc,
                         input logic [9:0] off, output logic [9:0] a, output logic w);
        longint unsigned per, k, ph, ph_prev;
        per = longint'(div) + 1;
        k   = longint'(n) / per;
        ph  = k * longint'(inc);
        a   = 10'((ph >> 22) + longint'(off));
        w   = 1'b0;
        if (n > 0 && (longint'(n) % per) == 0) begin
            ph_prev = (k - 1) * longint'(inc);
            w = ((ph >> 32) != (ph_prev >> 32));
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [9:0]  ea;
        logic        ew;
        logic [31:0] rdiv[2];
        logic [31:0] rinc[2];
        logic [9:0]  roff[2];
        logic [9:0]  b_addr[6];
        logic        b_wrap[6];
        logic        b_done[6];

        rst_n = 1'b0; ch_en = '0; start = '0; sync_in = 1'b0;
        cfg_we = 1'b0; cfg_ch = '0; cfg_sel = '0; cfg_data = '0;

        // ---- reset state ----
        step(3);
        chk("reset_addr", 32'(addr), 32'h0);
        chk("reset_wrap", 32'(wrap), 32'h0);
        chk("reset_done", 32'(done), 32'h0);
        rst_n = 1'b1;
        step(1);
        chk("idle_addr", 32'(addr), 32'h0);

        // ---- directed vector table (channel 0, continuous) ----
        vecs.push_back('{32'd3, 32'h0040_0000, 10'd0,    0,   10'd0,    1'b0});
        vecs.push_back('{32'd3, 32'h0040_0000, 10'd0,    3,   10'd0,    1'b0});
        vecs.push_back('{32'd3, 32'h0040_0000, 10'd0,    4,   10'd1,    1'b0});
        vecs.push_back('{32'd3, 32'h0040_0000, 10'd0,    8,   10'd2,    1'b0});
        vecs.push_back('{32'd3, 32'h0040_0000, 10'd0,    4092, 10'd1023, 1'b0});
        vecs.push_back('{32'd3, 32'h0040_0000, 10'd0,    4096, 10'd0,   1'b1});
        vecs.push_back('{32'd3, 32'h0040_0000, 10'd0,    4097, 10'd0,   1'b0});
        vecs.push_back('{32'd0, 32'h0060_0000, 10'd0,    1,   10'd1,    1'b0});
        vecs.push_back('{32'd0, 32'h0060_0000, 10'd0,    3,   10'd4,    1'b0});
        vecs.push_back('{32'd0, 32'h0060_0000, 10'd0,    6,   10'd9,    1'b0});
        vecs.push_back('{32'd0, 32'h8000_0000, 10'd0,    2,   10'd0,    1'b1});
        vecs.push_back('{32'd1, 32'h0040_0000, 10'd256,  2,   10'd257,  1'b0});
        vecs.push_back('{32'd0, 32'h0040_0000, 10'd1023, 1,   10'd0,    1'b0});

        foreach (vecs[i]) begin
            ch_en = '0;
            step(1);
            setup(0, vecs[i].div, vecs[i].inc, 32'(vecs[i].off), 32'h0);
            ch_en = 2'b01;
            step(1);
            if (vecs[i].cyc > 0) step(vecs[i].cyc);
            $display("vec %0d: div=%0d inc=%h off=%0d cyc=%0d addr=%0d wrap=%0d",
                     i, vecs[i].div, vecs[i].inc, vecs[i].off, vecs[i].cyc, addr[0], wrap[0]);
            chk($sformatf("vec%0d_addr", i), 32'(addr[0]), 32'(vecs[i].exp_addr));
            chk($sformatf("vec%0d_wrap", i), 32'(wrap[0]), 32'(vecs[i].exp_wrap));
        end

        // ---- randomized continuous runs on both channels ----
        for (int t = 0; t < 16; t++) begin
            ch_en = '0;
            step(1);
            for (int c = 0; c < 2; c++) begin
                rdiv[c] = $urandom_range(0, 3);
                rinc[c] = $urandom;
                roff[c] = 10'($urandom);
                setup(c, rdiv[c], rinc[c], 32'(roff[c]), 32'h0);
            end
            ch_en = 2'b11;
            step(1);
            $display("rand %0d: ch0 div=%0d inc=%h off=%0d ch1 div=%0d inc=%h off=%0d",
                     t, rdiv[0], rinc[0], roff[0], rdiv[1], rinc[1], roff[1]);
            for (int n = 0; n < 40; n++) begin
                for (int c = 0; c < 2; c++) begin
                    model(n, rdiv[c], rinc[c], roff[c], ea, ew);
                    chk($sformatf("rand%0d_ch%0d_n%0d_addr", t, c, n), 32'(addr[c]), 32'(ea));
                    chk($sformatf("rand%0d_ch%0d_n%0d_wrap", t, c, n), 32'(wrap[c]), 32'(ew));
                end
                step(1);
            end
        end

        // ---- burst mode: count 2, half-cycle increment ----
        ch_en = '0;
        step(1);
        setup(0, 32'd0, 32'h8000_0000, 32'd0, (32'd2 << 16) | 32'd1);
        ch_en = 2'b01;
        step(3);
        chk("burst_wait_addr", 32'(addr[0]), 32'd0);
        chk("burst_wait_done", 32'(done[0]), 32'd0);
        b_addr = '{10'd512, 10'd0, 10'd512, 10'd0, 10'd0, 10'd0};
        b_wrap = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        b_done = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        for (int r = 0; r < 2; r++) begin
            start = 2'b01;
            step(1);
            start = 2'b00;
            chk($sformatf("burst%0d_start_done", r), 32'(done[0]), 32'd0);
            for (int s = 0; s < 6; s++) begin
                step(1);
                $display("burst %0d step %0d: addr=%0d wrap=%0d done=%0d", r, s, addr[0], wrap[0], done[0]);
                chk($sformatf("burst%0d_s%0d_addr", r, s), 32'(addr[0]), 32'(b_addr[s]));
                chk($sformatf("burst%0d_s%0d_wrap", r, s), 32'(wrap[0]), 32'(b_wrap[s]));
                chk($sformatf("burst%0d_s%0d_done", r, s), 32'(done[0]), 32'(b_done[s]));
            end
        end
        ch_en = '0;
        step(1);
        chk("burst_disable_done", 32'(done[0]), 32'd0);

        // ---- retune while running: commits only at wrap ----
        setup(0, 32'd0, 32'h4000_0000, 32'd0, 32'h0);
        ch_en = 2'b01;
        step(1);
        step(1);
        chk("retune_e1_addr", 32'(addr[0]), 32'd256);
        cfg_wr(0, 1, 32'h8000_0000);
        chk("retune_e2_addr", 32'(addr[0]), 32'd512);
        step(1);
        chk("retune_e3_addr", 32'(addr[0]), 32'd768);
        step(1);
        chk("retune_e4_addr", 32'(addr[0]), 32'd0);
        chk("retune_e4_wrap", 32'(wrap[0]), 32'd1);
        step(1);
        chk("retune_e5_addr", 32'(addr[0]), 32'd512);
        step(1);
        chk("retune_e6_addr", 32'(addr[0]), 32'd0);
        cfg_wr(0, 1, 32'h4000_0000);
        chk("retune_e7_addr", 32'(addr[0]), 32'd512);
        cfg_wr(0, 1, 32'h2000_0000);
        chk("retune_e8_addr", 32'(addr[0]), 32'd0);
        chk("retune_e8_wrap", 32'(wrap[0]), 32'd1);
        step(1);
        $display("retune: after coincident write addr=%0d", addr[0]);
        chk("retune_e9_addr", 32'(addr[0]), 32'd256);
        step(3);
        chk("retune_e12_wrap", 32'(wrap[0]), 32'd1);
        step(1);
        chk("retune_e13_addr", 32'(addr[0]), 32'd128);

        // ---- sync_in aligns channels at different phases ----
        ch_en = '0;
        step(1);
        setup(0, 32'd0, 32'h0100_0000, 32'd0, 32'h0);
        setup(1, 32'd0, 32'h0100_0000, 32'd256, 32'h0);
        ch_en = 2'b01;
        step(3);
        ch_en = 2'b11;
        step(2);
        sync_in = 1'b1;
        step(1);
        sync_in = 1'b0;
        $display("sync: addr0=%0d addr1=%0d", addr[0], addr[1]);
        chk("sync_addr0", 32'(addr[0]), 32'd0);
        chk("sync_addr1", 32'(addr[1]), 32'd256);
        chk("sync_wrap", 32'(wrap), 32'd0);
        for (int k = 1; k <= 3; k++) begin
            step(1);
            chk($sformatf("sync_k%0d_addr0", k), 32'(addr[0]), 32'(4 * k));
            chk($sformatf("sync_k%0d_addr1", k), 32'(addr[1]), 32'(256 + 4 * k));
        end

        // ---- asynchronous reset mid-run ----
        ch_en = '0;
        step(1);
        setup(0, 32'd0, 32'h0300_0000, 32'd0, 32'h0);
        setup(1, 32'd0, 32'h8000_0000, 32'd5, (32'd1 << 16) | 32'd1);
        ch_en = 2'b11;
        step(1);
        start = 2'b10;
        step(1);
        start = 2'b00;
        step(4);
        chk("areset_pre_done1", 32'(done[1]), 32'd1);
        chk("areset_pre_addr1", 32'(addr[1]), 32'd5);
        #2;
        rst_n = 1'b0;
        #1;
        $display("async reset: addr=%h wrap=%b done=%b", addr, wrap, done);
        chk("areset_addr", 32'(addr), 32'd0);
        chk("areset_wrap", 32'(wrap), 32'd0);
        chk("areset_done", 32'(done), 32'd0);
        #2;
        rst_n = 1'b1;
        step(1);
        chk("post_reset_e0_addr0", 32'(addr[0]), 32'd0);
        step(1);
        chk("post_reset_e1_addr0", 32'(addr[0]), 32'd1);
        chk("post_reset_e1_addr1", 32'(addr[1]), 32'd1);
        step(1);
        chk("post_reset_e2_addr0", 32'(addr[0]), 32'd2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
